// File: rtl/dma_read_initiator.sv
// dma_read_initiator: Wishbone read initiator for the SDRAM DMA window.
// A cfg_start pulse latches a word-aligned byte address and a word count. The block then
// issues one single-word read at a time to {9'h0F0, addr}. Each returned word goes into a
// local FIFO, which the consumer drains through a valid/ready stream.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   cfg_start/addr/len   transfer request (accepted only when idle)
//   cfg_abort            finish after the word currently in flight
//   busy, done, err      status (done is a 1-cycle pulse, err is a sticky timeout flag)
//   words_done           words captured for the current or last transfer
//   stat_burst_hits      acks that arrived with dma_burst_valid_i set
//   dma_wbs_*            Wishbone initiator port (read-only)
//   m_data/valid/ready   output stream (FIFO head)
module dma_read_initiator #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [22:0]      cfg_addr,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             dma_wbs_cyc_o,
  output logic             dma_wbs_stb_o,
  output logic             dma_wbs_we_o,
  output logic [31:0]      dma_wbs_adr_o,
  input  logic             dma_wbs_ack_i,
  input  logic [31:0]      dma_wbs_dat_i,
  input  logic             dma_burst_valid_i,
  output logic [LEN_W-1:0] stat_burst_hits,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TmoLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {StIdle, StGap, StReq, StFin} state_e;

  state_e           state_q;
  logic [22:0]      addr_q;
  logic [LEN_W-1:0] remaining_q;
  logic             abort_q;
  logic [TmoW-1:0]  tmo_q;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  // Address bits [1:0] are forced to zero; the reads are word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cfg_addr[1:0];

  assign dma_wbs_we_o = 1'b0;

  // Only an ack for the read in flight is captured; stray acks are ignored.
  assign push = (state_q == StReq) && dma_wbs_ack_i;
  assign pop  = m_valid && m_ready;

  always_comb begin
    m_valid = (count_q != '0);
    m_data  = m_valid ? mem[rptr_q] : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remaining_q     <= '0;
      abort_q         <= 1'b0;
      tmo_q           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      words_done      <= '0;
      stat_burst_hits <= '0;
      dma_wbs_cyc_o   <= 1'b0;
      dma_wbs_stb_o   <= 1'b0;
      dma_wbs_adr_o   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            addr_q          <= {cfg_addr[22:2], 2'b00};
            remaining_q     <= cfg_len;
            words_done      <= '0;
            stat_burst_hits <= '0;
            err             <= 1'b0;
            abort_q         <= 1'b0;
            busy            <= 1'b1;
            state_q         <= (cfg_len == '0) ? StFin : StGap;
          end
        end
        StGap: begin
          if ((remaining_q == '0) || abort_q || cfg_abort) begin
            state_q <= StFin;
          end else if (count_q < CntW'(FIFO_DEPTH)) begin
            // Space is reserved here, so the push on ack can never overflow.
            state_q       <= StReq;
            dma_wbs_cyc_o <= 1'b1;
            dma_wbs_stb_o <= 1'b1;
            dma_wbs_adr_o <= {9'h0F0, addr_q};
            tmo_q         <= '0;
          end
        end
        StReq: begin
          if (cfg_abort) abort_q <= 1'b1;
          if (dma_wbs_ack_i) begin
            dma_wbs_cyc_o <= 1'b0;
            dma_wbs_stb_o <= 1'b0;
            addr_q        <= addr_q + 23'd4;
            remaining_q   <= remaining_q - LEN_W'(1);
            words_done    <= words_done + LEN_W'(1);
            if (dma_burst_valid_i) stat_burst_hits <= stat_burst_hits + LEN_W'(1);
            state_q       <= StGap;
          end else if ((TIMEOUT != 0) && (tmo_q == TmoW'(TmoLast))) begin
            err           <= 1'b1;
            dma_wbs_cyc_o <= 1'b0;
            dma_wbs_stb_o <= 1'b0;
            state_q       <= StFin;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StFin: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= dma_wbs_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_initiator.sv
module tb_dma_read_initiator;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_abort;
  logic [22:0] cfg_addr;
  logic [15:0] cfg_len;
  logic        busy, done, err;
  logic [15:0] words_done, stat_burst_hits;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic        ack;
  logic [31:0] dat;
  logic        bv;
  logic [31:0] m_data;
  logic        m_valid, m_ready;

  dma_read_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_abort(cfg_abort),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .dma_wbs_cyc_o(cyc), .dma_wbs_stb_o(stb), .dma_wbs_we_o(we), .dma_wbs_adr_o(adr),
    .dma_wbs_ack_i(ack), .dma_wbs_dat_i(dat), .dma_burst_valid_i(bv),
    .stat_burst_hits(stat_burst_hits),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave / consumer controls
  int  s_lat     = 2;
  int  s_cnt     = 0;
  bit  never_ack = 0;
  bit  rand_lat  = 0;
  bit  spurious  = 0;
  int  rdy_mode  = 1;   // 0 low, 1 high, 2 random

  // Instrumentation from the checker process
  logic [31:0] log_adr[$];
  int  done_cnt = 0, busy_cyc = 0, cyc_cyc = 0, stb_cyc = 0;
  bit  stb_prev = 0;

  // Reference model: transfer-level view of the spec.
  bit          mbusy = 0, mreq = 0, mfin = 0, mdone = 0, merr = 0, mabort = 0;
  logic [31:0] madr = 0;
  logic [22:0] mbase = 0;
  logic [15:0] mlen = 0, mwords = 0, mhits = 0;
  int          held = 0;
  logic [31:0] q[$];
  bit          chk_en = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc", 64'(cyc), 64'(mreq));
      chk("stb", 64'(stb), 64'(mreq));
      chk("we", 64'(we), 64'd0);
      chk("adr", 64'(adr), 64'(madr));
      chk("busy", 64'(busy), 64'(mbusy));
      chk("done", 64'(done), 64'(mdone));
      chk("err", 64'(err), 64'(merr));
      chk("words_done", 64'(words_done), 64'(mwords));
      chk("burst_hits", 64'(stat_burst_hits), 64'(mhits));
      chk("m_valid", 64'(m_valid), 64'(q.size() > 0));
      chk("m_data", 64'(m_data), 64'((q.size() > 0) ? q[0] : 32'd0));
    end
    if (stb && !stb_prev) log_adr.push_back(adr);
    stb_prev = stb;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    if (cyc) cyc_cyc++;
    if (stb) stb_cyc++;
    // Advance model by one clock using the inputs that the next edge will sample.
    if (rst) begin
      mbusy = 0; mreq = 0; mfin = 0; mdone = 0; merr = 0; mabort = 0;
      madr = 0; mwords = 0; mhits = 0; held = 0;
      q.delete();
      chk_en = 1;
    end else begin
      int sz;
      bit do_pop, do_push;
      logic [31:0] pdat;
      logic [22:0] na;
      sz      = q.size();
      do_pop  = (sz > 0) && m_ready;
      do_push = mreq && ack;
      pdat    = dat;
      mdone   = 0;
      if (!mbusy) begin
        if (cfg_start) begin
          mbase = {cfg_addr[22:2], 2'b00};
          mlen = cfg_len; mwords = 0; mhits = 0; merr = 0; mabort = 0;
          mbusy = 1;
          mfin = (cfg_len == 16'd0);
        end
      end else if (mfin) begin
        mdone = 1; mbusy = 0; mfin = 0;
      end else if (mreq) begin
        if (cfg_abort) mabort = 1;
        if (ack) begin
          mwords++;
          if (bv) mhits++;
          mreq = 0;
        end else if (held + 1 >= int'(TMO)) begin
          merr = 1; mreq = 0; mfin = 1;
        end else begin
          held++;
        end
      end else begin
        if (mlen == mwords || mabort || cfg_abort) begin
          mfin = 1;
        end else if (sz < int'(DEPTH)) begin
          mreq = 1; held = 0;
          na = mbase + 23'(mwords) * 23'd4;
          madr = {9'h0F0, na};
        end
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(pdat);
    end
  end

  // Wishbone slave and stream consumer
  initial forever begin
    @(posedge clk);
    #1;
    dat = $urandom;
    bv  = 1'($urandom % 2);
    m_ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom % 2);
    if (cyc && stb) begin
      ack = (!never_ack && s_cnt == s_lat);
      s_cnt++;
    end else begin
      s_cnt = 0;
      if (rand_lat) s_lat = int'($urandom % 4);
      ack = spurious && ($urandom % 8 == 0);
    end
  end

  task automatic start_xfer(input logic [22:0] a, input logic [15:0] l);
    @(posedge clk); #1;
    cfg_start = 1; cfg_addr = a; cfg_len = l;
    @(posedge clk); #1;
    cfg_start = 0;
  endtask

  task automatic clear_stats();
    log_adr.delete();
    done_cnt = 0; busy_cyc = 0; cyc_cyc = 0; stb_cyc = 0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; cfg_start = 0; cfg_abort = 0; cfg_addr = 0; cfg_len = 0;
    ack = 0; dat = 0; bv = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_cyc", 64'(cyc), 64'd0);
    chk("reset_adr", 64'(adr), 64'd0);
    chk("reset_valid", 64'(m_valid), 64'd0);

    // 1: four reads, ack two cycles after stb
    s_lat = 2; rdy_mode = 1; clear_stats();
    start_xfer(23'h000100, 16'd4);
    wait_idle(200);
    chk("t1_nreads", 64'(log_adr.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_adr.size(); i++)
      chk("t1_adr", 64'(log_adr[i]), 64'(32'h7800_0100 + 32'(4 * i)));
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_words", 64'(words_done), 64'd4);

    // 2: zero length
    clear_stats();
    start_xfer(23'h000040, 16'd0);
    wait_idle(20);
    chk("t2_busy_cycles", 64'(busy_cyc), 64'd1);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_no_cyc", 64'(cyc_cyc), 64'd0);

    // 3: FIFO back-pressure
    s_lat = 1; rdy_mode = 0; clear_stats();
    start_xfer(23'h000200, 16'd12);
    repeat (60) @(negedge clk);
    chk("t3_reads_full", 64'(log_adr.size()), 64'd8);
    chk("t3_cyc_low", 64'(cyc), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rdy_mode = 1;
    wait_idle(300);
    chk("t3_reads_all", 64'(log_adr.size()), 64'd12);
    chk("t3_words", 64'(words_done), 64'd12);

    // 4: ack timeout
    never_ack = 1; clear_stats();
    start_xfer(23'h000300, 16'd2);
    wait_idle(400);
    chk("t4_stb_cycles", 64'(stb_cyc), 64'd255);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);
    never_ack = 0; s_lat = 0;
    start_xfer(23'h000400, 16'd1);
    chk("t4_err_cleared", 64'(err), 64'd0);
    wait_idle(100);

    // 5: address wrap
    s_lat = 1; clear_stats();
    start_xfer(23'h7FFFF8, 16'd3);
    wait_idle(100);
    chk("t5_nreads", 64'(log_adr.size()), 64'd3);
    if (log_adr.size() == 3) begin
      chk("t5_adr0", 64'(log_adr[0]), 64'h787F_FFF8);
      chk("t5_adr1", 64'(log_adr[1]), 64'h787F_FFFC);
      chk("t5_adr2", 64'(log_adr[2]), 64'h7800_0000);
    end

    // 6: abort during the second request
    s_lat = 4; clear_stats();
    start_xfer(23'h000500, 16'd10);
    for (int n = 0; n < 100 && log_adr.size() < 2; n++) @(negedge clk);
    @(posedge clk); #1 cfg_abort = 1;
    @(posedge clk); #1 cfg_abort = 0;
    wait_idle(100);
    chk("t6_nreads", 64'(log_adr.size()), 64'd2);
    chk("t6_words", 64'(words_done), 64'd2);
    chk("t6_done_cnt", 64'(done_cnt), 64'd1);

    // Reset in the middle of a transfer
    s_lat = 3; rdy_mode = 0;
    start_xfer(23'h000600, 16'd6);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("rst_mid_cyc", 64'(cyc), 64'd0);
    chk("rst_mid_valid", 64'(m_valid), 64'd0);

    // Random phase: random starts, aborts, latencies, stray acks and back-pressure.
    rand_lat = 1; spurious = 1; rdy_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      cfg_start = ($urandom % 20 == 0);
      cfg_addr  = ($urandom % 4 == 0) ? 23'(23'h7FFFE0 + ($urandom % 32)) : 23'($urandom);
      cfg_len   = 16'($urandom % 13);
      cfg_abort = ($urandom % 60 == 0);
    end
    @(posedge clk); #1;
    cfg_start = 0; cfg_abort = 0; rdy_mode = 1;
    wait_idle(500);
    repeat (20) @(posedge clk);
    #1;
    chk("final_drained", 64'(m_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
